// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel receive stage.
// Holds the default word geometry and the frame-assembly state type.
package deser_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_MOD_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/deserializer_if.sv
// Bundle of the deserializer's serial input and parallel output signals.
// Ports:
//   ser_data_i / ser_data_val_i / ser_last_i : serial bit, strobe, end-of-frame
//   data_o / data_mod_o / data_val_o         : left-aligned word, bit count, pulse
//   busy_o                                   : frame partially received
// slave  : the deserializer side (consumes serial, produces parallel)
// master : the side feeding bits in and watching words come out
interface deserializer_if #(
  parameter int unsigned WIDTH = deser_pkg::DEF_WIDTH,
  parameter int unsigned MOD_W = deser_pkg::DEF_MOD_W
);

  logic             ser_data_i;
  logic             ser_data_val_i;
  logic             ser_last_i;
  logic [WIDTH-1:0] data_o;
  logic [MOD_W-1:0] data_mod_o;
  logic             data_val_o;
  logic             busy_o;

  modport slave (
    input  ser_data_i, ser_data_val_i, ser_last_i,
    output data_o, data_mod_o, data_val_o, busy_o
  );

  modport master (
    output ser_data_i, ser_data_val_i, ser_last_i,
    input  data_o, data_mod_o, data_val_o, busy_o
  );

endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bits into a left-aligned
// word, completing after WIDTH bits or on an end-of-frame marker.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   bus   : deserializer_if.slave (serial in, word/count/pulse/busy out)
module deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MOD_W = DEF_MOD_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  deserializer_if.slave  bus
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [MOD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [MOD_W-1:0] mod_q, mod_d;
  logic             val_q, val_d;
  logic [IDX_W-1:0] pos;

  // Shift-register slot for the next bit: WIDTH-1 for the first bit of a frame.
  assign pos = IDX_W'(WIDTH - 1) - IDX_W'(cnt_q);

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
    end
  end

  // Bit acceptance and frame completion; the shift register is cleared on
  // completion so the unfilled LSBs of the next word are already zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    if (bus.ser_data_val_i) begin
      shift_d[pos] = bus.ser_data_i;
      if (bus.ser_last_i || (cnt_q == MOD_W'(WIDTH - 1))) begin
        data_d  = shift_d;
        mod_d   = cnt_q + MOD_W'(1);
        val_d   = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + MOD_W'(1);
        state_d = COLLECT;
      end
    end
  end

  assign bus.data_o     = data_q;
  assign bus.data_mod_o = mod_q;
  assign bus.data_val_o = val_q;
  assign bus.busy_o     = (state_q == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for the deserializer: table of frames sent back to
// back, a reset-mid-frame sequence and a randomized serializer-style loopback.
module tb_deserializer;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = 5;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  deserializer_if #(.WIDTH(W), .MOD_W(MW)) bus ();

  deserializer #(.WIDTH(W), .MOD_W(MW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  d;
    logic [MW-1:0] m;
    int            c;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [W-1:0]  d;
    int            n;
    logic          last;
    int            ga;
    int            gb;
    int            gl;
    logic [W-1:0]  ed;
    logic [MW-1:0] em;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.data_val_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(bus.data_val_o), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_o", 32'(bus.data_o), 32'(e.d));
        chk("data_mod_o", 32'(bus.data_mod_o), 32'(e.m));
        chk("latency", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic send_frame(input logic [W-1:0] d, input int n, input logic last,
                            input int ga, input int gb, input int gl,
                            input logic [W-1:0] ed, input logic [MW-1:0] em);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_bit", 32'(bus.busy_o), 32'(i > 0));
      bus.ser_data_i     = d[W-1-i];
      bus.ser_data_val_i = 1'b1;
      bus.ser_last_i     = last && (i == n - 1);
      if (i == n - 1) begin
        exp_t e;
        e.d = ed;
        e.m = em;
        e.c = cyc + 1;
        sb.push_back(e);
      end
      if ((i + 1 == ga) || (i + 1 == gb)) begin
        for (int g = 0; g < gl; g++) begin
          @(negedge clk);
          if (g > 0) chk("busy_gap", 32'(bus.busy_o), 32'(i + 1 < n));
          bus.ser_data_val_i = 1'b0;
          bus.ser_last_i     = 1'b1;
          bus.ser_data_i     = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ser_data_val_i = 1'b0;
      bus.ser_last_i     = 1'b0;
      bus.ser_data_i     = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_o"}, 32'(bus.data_o), 32'h0);
    chk({tag, "_data_mod_o"}, 32'(bus.data_mod_o), 32'h0);
    chk({tag, "_data_val_o"}, 32'(bus.data_val_o), 32'h0);
    chk({tag, "_busy_o"}, 32'(bus.busy_o), 32'h0);
  endtask

  initial begin
    logic [W-1:0] rd, mask;
    int           rn;
    logic         rl;

    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    bus.ser_last_i     = 1'b0;

    tbl[0] = '{16'hA5C3, 16, 1'b0, 0, 0, 0, 16'hA5C3, 5'd16};
    tbl[1] = '{16'hB000,  5, 1'b1, 0, 0, 0, 16'hB000, 5'd5};
    tbl[2] = '{16'h8000,  1, 1'b1, 0, 0, 0, 16'h8000, 5'd1};
    tbl[3] = '{16'hF0F0, 16, 1'b0, 4, 9, 3, 16'hF0F0, 5'd16};
    tbl[4] = '{16'h1234, 16, 1'b0, 0, 0, 0, 16'h1234, 5'd16};
    tbl[5] = '{16'hE000,  3, 1'b1, 0, 0, 0, 16'hE000, 5'd3};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // All table frames go in back to back with no idle cycle between them.
    for (int k = 0; k < 6; k++)
      send_frame(tbl[k].d, tbl[k].n, tbl[k].last, tbl[k].ga, tbl[k].gb,
                 tbl[k].gl, tbl[k].ed, tbl[k].em);
    idle(4);
    chk("hold_data_o", 32'(bus.data_o), 32'h0000E000);
    chk("hold_data_mod_o", 32'(bus.data_mod_o), 32'd3);
    chk("hold_busy_o", 32'(bus.busy_o), 32'h0);

    // Partial frame discarded by reset.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.ser_data_i     = 1'b1;
      bus.ser_data_val_i = 1'b1;
      bus.ser_last_i     = 1'b0;
    end
    @(negedge clk);
    chk("busy_before_rst", 32'(bus.busy_o), 32'h1);
    rst                = 1'b1;
    bus.ser_data_val_i = 1'b1;
    bus.ser_last_i     = 1'b1;
    @(negedge clk);
    rst                = 1'b0;
    bus.ser_data_val_i = 1'b0;
    bus.ser_last_i     = 1'b0;
    chk_zero("midrst");
    send_frame(16'hFFFF, 16, 1'b0, 0, 0, 0, 16'hFFFF, 5'd16);
    idle(3);

    // Serializer-style loopback with random lengths and occasional stalls.
    for (int t = 0; t < 200; t++) begin
      rd   = W'($urandom);
      rn   = $urandom_range(1, 16);
      mask = (rn == 16) ? 16'hFFFF : ~(16'hFFFF >> rn);
      rl   = (rn < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(rd, rn, rl, $urandom_range(0, rn), 0, $urandom_range(1, 2),
                 rd & mask, MW'(rn));
    end
    idle(2);

    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_pulse", 32'h0, 32'(e.d));
      if (e.d == '0) begin
        errors++;
        $display("FAIL missing_pulse actual=none required=%0h/%0d", e.d, e.m);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
